// File: rtl/apb_pkg.sv
// Shared types and elaboration helpers for the parametrised APB memory slave.
package apb_pkg;

   typedef enum logic [0:0] {APB_IDLE, APB_ACCESS} apb_state_t;

   localparam logic APB_OKAY   = 1'b0;
   localparam logic APB_SLVERR = 1'b1;

   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      while ((32'd1 << r) < v) r++;
      return r;
   endfunction

   function automatic int unsigned byte_lanes(input int unsigned data_w);
      return data_w / 8;
   endfunction

endpackage

// File: rtl/apb_sram_array.sv
// Word array with synchronous write and combinational read on one shared address.
// With APB_PSTRB_EN defined, writes are masked per byte lane by strb.
module apb_sram_array
   import apb_pkg::*;
#(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned DEPTH  = 32,
   parameter int unsigned IDX_W  = 5
) (
   input  logic              clk,
   input  logic              we,
   input  logic [IDX_W-1:0]  addr,
   input  logic [DATA_W-1:0] wdata,
`ifdef APB_PSTRB_EN
   input  logic [DATA_W/8-1:0] strb,
`endif
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

`ifdef APB_PSTRB_EN
   localparam int unsigned LANES = byte_lanes(DATA_W);

   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < LANES; i++) begin
            if (strb[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
         end
      end
   end
`else
   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
   end
`endif

   assign rdata = mem[addr];

endmodule

// File: rtl/apb_slave_mem.sv
// APB slave over a word array: wait states, PSLVERR on range/alignment errors, abort support.
// Define APB_PSTRB_EN to add the pstrb byte-lane write strobe port.
module apb_slave_mem
   import apb_pkg::*;
#(
   parameter int unsigned       DATA_W      = 32,
   parameter int unsigned       ADDR_W      = 32,
   parameter int unsigned       DEPTH       = 32,
   parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
   parameter int unsigned       WAIT_CYCLES = 0
) (
   input  logic              pclk,
   input  logic              prst,
   input  logic [ADDR_W-1:0] paddr,
   input  logic              pselx,
   input  logic              penable,
   input  logic              pwrite,
   input  logic [DATA_W-1:0] pwdata,
`ifdef APB_PSTRB_EN
   input  logic [DATA_W/8-1:0] pstrb,
`endif
   output logic              pready,
   output logic              pslverr,
   output logic [DATA_W-1:0] prdata
);

   localparam int unsigned       LANES     = byte_lanes(DATA_W);
   localparam int unsigned       LB        = clog2(LANES);
   localparam int unsigned       IDX_W     = clog2(DEPTH);
   localparam logic [ADDR_W-1:0] SPAN      = ADDR_W'(DEPTH * LANES);
   localparam logic [ADDR_W-1:0] LANE_MASK = ADDR_W'(LANES - 1);

   apb_state_t        state_q, state_d;
   logic [3:0]        count_q, count_d;
   logic [IDX_W-1:0]  idx_q;
   logic              err_q;
   logic              pwrite_q;
   logic [DATA_W-1:0] prdata_q;

   logic [ADDR_W-1:0] offset;
   logic [IDX_W-1:0]  idx_w;
   logic              err_w;
   logic              setup;
   logic              mem_we;
   logic [IDX_W-1:0]  mem_addr;
   logic [DATA_W-1:0] mem_rdata;

   // Addresses below BASE_ADDR wrap to a huge offset and fall into the range error.
   assign offset = paddr - BASE_ADDR;
   assign idx_w  = IDX_W'(offset >> LB);
   assign err_w  = (offset >= SPAN) || ((offset & LANE_MASK) != '0);

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      setup   = 1'b0;
      mem_we  = 1'b0;
      unique case (state_q)
         APB_IDLE: begin
            if (pselx && !penable) begin
               state_d = APB_ACCESS;
               count_d = 4'(WAIT_CYCLES);
               setup   = 1'b1;
            end
         end
         APB_ACCESS: begin
            if (pselx && penable) begin
               if (count_q != '0) begin
                  count_d = count_q - 4'd1;
               end else begin
                  state_d = APB_IDLE;
                  mem_we  = pwrite_q && !err_q;
               end
            end else begin
               state_d = APB_IDLE;
            end
         end
         default: state_d = APB_IDLE;
      endcase
   end

   always_ff @(posedge pclk or posedge prst) begin
      if (prst) begin
         state_q  <= APB_IDLE;
         count_q  <= '0;
         idx_q    <= '0;
         err_q    <= 1'b0;
         pwrite_q <= 1'b0;
         prdata_q <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         if (setup) begin
            idx_q    <= idx_w;
            err_q    <= err_w;
            pwrite_q <= pwrite;
            if (!pwrite) prdata_q <= err_w ? '0 : mem_rdata;
         end
      end
   end

   // Reads index from the live bus in IDLE; writes land in ACCESS from the latched index.
   assign mem_addr = (state_q == APB_IDLE) ? idx_w : idx_q;

   apb_sram_array #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .IDX_W  (IDX_W)
   ) u_array (
      .clk   (pclk),
      .we    (mem_we),
      .addr  (mem_addr),
      .wdata (pwdata),
`ifdef APB_PSTRB_EN
      .strb  (pstrb),
`endif
      .rdata (mem_rdata)
   );

   assign pready  = (state_q == APB_ACCESS) && (count_q == '0);
   assign pslverr = pready ? (err_q ? APB_SLVERR : APB_OKAY) : 1'b0;
   assign prdata  = prdata_q;

endmodule

// File: tb/tb_apb_slave_mem.sv
// Directed bench for apb_slave_mem: three instances with WAIT_CYCLES 0, 3 and 2 on a shared bus.
// Under APB_PSTRB_EN the byte-strobe scenario is added.
module tb_apb_slave_mem;

   logic        pclk = 1'b0;
   logic        prst = 1'b1;
   logic [31:0] paddr = '0;
   logic        penable = 1'b0;
   logic        pwrite = 1'b0;
   logic [31:0] pwdata = '0;
   logic        sel  [3];
   logic        rdy  [3];
   logic        serr [3];
   logic [31:0] rdat [3];
`ifdef APB_PSTRB_EN
   logic [3:0]  pstrb = 4'hF;
`endif

   int vec  = 0;
   int miss = 0;
   int cyc  = 0;

   always #5 pclk = ~pclk;
   always @(posedge pclk) cyc <= cyc + 1;

   apb_slave_mem #(.WAIT_CYCLES(0)) dut0 (
      .pclk(pclk), .prst(prst), .paddr(paddr), .pselx(sel[0]), .penable(penable),
      .pwrite(pwrite), .pwdata(pwdata),
`ifdef APB_PSTRB_EN
      .pstrb(pstrb),
`endif
      .pready(rdy[0]), .pslverr(serr[0]), .prdata(rdat[0]));

   apb_slave_mem #(.WAIT_CYCLES(3)) dut1 (
      .pclk(pclk), .prst(prst), .paddr(paddr), .pselx(sel[1]), .penable(penable),
      .pwrite(pwrite), .pwdata(pwdata),
`ifdef APB_PSTRB_EN
      .pstrb(pstrb),
`endif
      .pready(rdy[1]), .pslverr(serr[1]), .prdata(rdat[1]));

   apb_slave_mem #(.WAIT_CYCLES(2)) dut2 (
      .pclk(pclk), .prst(prst), .paddr(paddr), .pselx(sel[2]), .penable(penable),
      .pwrite(pwrite), .pwdata(pwdata),
`ifdef APB_PSTRB_EN
      .pstrb(pstrb),
`endif
      .pready(rdy[2]), .pslverr(serr[2]), .prdata(rdat[2]));

   // Full transfer on instance d; call at a negedge, returns at a negedge with the bus idle.
   task automatic xfer(input int d, input logic wr, input logic [31:0] addr,
                       input logic [31:0] data, output int waits, output logic err,
                       output logic [31:0] rd);
      sel[d] = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data;
      @(negedge pclk);
      penable = 1'b1;
      waits = 0; err = 1'bx; rd = 'x;
      while (rdy[d] !== 1'b1 && waits < 40) begin
         @(negedge pclk);
         waits++;
      end
      vec++;
      if (rdy[d] !== 1'b1) begin
         miss++;
         $display("FAIL xfer_timeout dut%0d addr=%h: pready=%b, required 1", d, addr, rdy[d]);
      end else begin
         err = serr[d];
         rd  = rdat[d];
      end
      @(negedge pclk);
      sel[d] = 1'b0; penable = 1'b0;
   endtask

   task automatic test_reset();
      #12;
      for (int d = 0; d < 3; d++) begin
         vec++;
         if (rdy[d] !== 1'b0 || serr[d] !== 1'b0 || rdat[d] !== 32'h0) begin
            miss++;
            $display("FAIL reset dut%0d: pready=%b pslverr=%b prdata=%h, required 0 0 0",
                     d, rdy[d], serr[d], rdat[d]);
         end
      end
      @(negedge pclk);
      prst = 1'b0;
      @(negedge pclk);
   endtask

   task automatic test_basic();
      int w; logic e; logic [31:0] r;
      xfer(0, 1'b1, 32'h08, 32'hDEADBEEF, w, e, r);
      vec++;
      if (w !== 0 || e !== 1'b0) begin
         miss++; $display("FAIL basic_write: waits=%0d err=%b, required 0 0", w, e);
      end
      xfer(0, 1'b0, 32'h08, 32'h0, w, e, r);
      vec++;
      if (w !== 0 || e !== 1'b0) begin
         miss++; $display("FAIL basic_read_resp: waits=%0d err=%b, required 0 0", w, e);
      end
      vec++;
      if (r !== 32'hDEADBEEF) begin
         miss++; $display("FAIL basic_read_data: got %h, required deadbeef", r);
      end
   endtask

   task automatic test_wait_states();
      int w; logic e; logic [31:0] r;
      xfer(1, 1'b1, 32'h04, 32'h0BADF00D, w, e, r);
      vec++;
      if (w !== 3) begin
         miss++; $display("FAIL wait_write: waits=%0d, required 3", w);
      end
      xfer(1, 1'b0, 32'h04, 32'h0, w, e, r);
      vec++;
      if (w !== 3 || e !== 1'b0 || r !== 32'h0BADF00D) begin
         miss++;
         $display("FAIL wait_read: waits=%0d err=%b data=%h, required 3 0 0badf00d", w, e, r);
      end
   endtask

   task automatic test_errors();
      int w; logic e; logic [31:0] r;
      xfer(0, 1'b1, 32'h04, 32'h11112222, w, e, r);
      xfer(0, 1'b0, 32'h80, 32'h0, w, e, r);
      vec++;
      if (e !== 1'b1 || r !== 32'h0) begin
         miss++; $display("FAIL err_range_read: err=%b data=%h, required 1 00000000", e, r);
      end
      xfer(0, 1'b1, 32'h06, 32'hFFFFFFFF, w, e, r);
      vec++;
      if (e !== 1'b1) begin
         miss++; $display("FAIL err_misaligned_write: err=%b, required 1", e);
      end
      vec++;
      if (serr[0] !== 1'b0) begin
         miss++; $display("FAIL err_idle_pslverr: pslverr=%b, required 0", serr[0]);
      end
      xfer(0, 1'b0, 32'h04, 32'h0, w, e, r);
      vec++;
      if (e !== 1'b0 || r !== 32'h11112222) begin
         miss++; $display("FAIL err_reread: err=%b data=%h, required 0 11112222", e, r);
      end
      xfer(0, 1'b1, 32'h7C, 32'h7C7C7C7C, w, e, r);
      xfer(0, 1'b0, 32'h7C, 32'h0, w, e, r);
      vec++;
      if (e !== 1'b0 || r !== 32'h7C7C7C7C) begin
         miss++; $display("FAIL err_last_word: err=%b data=%h, required 0 7c7c7c7c", e, r);
      end
   endtask

   task automatic test_abort();
      int w; logic e; logic [31:0] r;
      xfer(2, 1'b1, 32'h10, 32'hAAAA5555, w, e, r);
      sel[2] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h10; pwdata = 32'h12345678;
      @(negedge pclk);
      penable = 1'b1;
      @(negedge pclk);
      sel[2] = 1'b0; penable = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge pclk);
         vec++;
         if (rdy[2] !== 1'b0 || serr[2] !== 1'b0) begin
            miss++;
            $display("FAIL abort_idle[%0d]: pready=%b pslverr=%b, required 0 0", i, rdy[2], serr[2]);
         end
      end
      xfer(2, 1'b0, 32'h10, 32'h0, w, e, r);
      vec++;
      if (w !== 2 || r !== 32'hAAAA5555) begin
         miss++; $display("FAIL abort_reread: waits=%0d data=%h, required 2 aaaa5555", w, r);
      end
   endtask

   task automatic test_back_to_back();
      int w; logic e; logic [31:0] r; int c0;
      c0 = cyc;
      xfer(0, 1'b1, 32'h0C, 32'hCAFEF00D, w, e, r);
      xfer(0, 1'b0, 32'h0C, 32'h0, w, e, r);
      vec++;
      if (cyc - c0 !== 4) begin
         miss++; $display("FAIL b2b_cycles: got %0d, required 4", cyc - c0);
      end
      vec++;
      if (r !== 32'hCAFEF00D) begin
         miss++; $display("FAIL b2b_data: got %h, required cafef00d", r);
      end
   endtask

   task automatic test_async_reset();
      int w; logic e; logic [31:0] r;
      sel[0] = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h08;
      @(negedge pclk);
      penable = 1'b1;
      vec++;
      if (rdy[0] !== 1'b1 || rdat[0] !== 32'hDEADBEEF) begin
         miss++;
         $display("FAIL arst_pre: pready=%b data=%h, required 1 deadbeef", rdy[0], rdat[0]);
      end
      #2 prst = 1'b1;
      #1;
      vec++;
      if (rdy[0] !== 1'b0 || serr[0] !== 1'b0 || rdat[0] !== 32'h0) begin
         miss++;
         $display("FAIL arst_now: pready=%b pslverr=%b data=%h, required 0 0 00000000",
                  rdy[0], serr[0], rdat[0]);
      end
      @(negedge pclk);
      prst = 1'b0; sel[0] = 1'b0; penable = 1'b0;
      @(negedge pclk);
      xfer(0, 1'b0, 32'h08, 32'h0, w, e, r);
      vec++;
      if (w !== 0 || e !== 1'b0 || r !== 32'hDEADBEEF) begin
         miss++;
         $display("FAIL arst_after: waits=%0d err=%b data=%h, required 0 0 deadbeef", w, e, r);
      end
   endtask

`ifdef APB_PSTRB_EN
   task automatic test_pstrb();
      int w; logic e; logic [31:0] r;
      pstrb = 4'hF;
      xfer(0, 1'b1, 32'h14, 32'hFFFFFFFF, w, e, r);
      pstrb = 4'b0101;
      xfer(0, 1'b1, 32'h14, 32'h00000000, w, e, r);
      pstrb = 4'b0000;
      xfer(0, 1'b1, 32'h14, 32'h12345678, w, e, r);
      vec++;
      if (e !== 1'b0) begin
         miss++; $display("FAIL pstrb_zero_resp: err=%b, required 0", e);
      end
      pstrb = 4'b0000;
      xfer(0, 1'b0, 32'h14, 32'h0, w, e, r);
      vec++;
      if (r !== 32'hFF00FF00) begin
         miss++; $display("FAIL pstrb_data: got %h, required ff00ff00", r);
      end
      pstrb = 4'hF;
   endtask
`endif

   initial begin
      for (int d = 0; d < 3; d++) sel[d] = 1'b0;
      test_reset();
      test_basic();
      test_wait_states();
      test_errors();
      test_abort();
      test_back_to_back();
      test_async_reset();
`ifdef APB_PSTRB_EN
      test_pstrb();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
      $finish;
   end

endmodule
